// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
// Bundles the pipeline-register signals between the stall controller and
// upstream stage on one side and pipe_stage_reg on the other.
//
// Handshake: this link has no valid/ready pair. When it is not stalled, the
// register captures the upstream payload on every clock edge. in_valid_i
// marks a real instruction, and out_valid_o marks one that has been latched.
// Backpressure comes only from stall_down_i (hold) and stall_up_i (bubble).
// flush_i overrides both.
//
// Signals (direction seen from the register, i.e. the slave modport):
//   stall_up_i       in   upstream stage stalled this cycle
//   stall_down_i     in   this/downstream stage stalled, register holds
//   flush_i          in   discard contents
//   in_valid_i       in   upstream payload is a real instruction
//   in_data_i        in   upstream payload (DATA_W)
//   in_next_dslot_i  in   next upstream instruction sits in a delay slot
//   cnt_clr_i        in   synchronous clear of both profiling counters
//   out_valid_o      out  registered valid
//   out_data_o       out  registered payload (DATA_W)
//   dslot_fb_o       out  registered delay-slot flag back to upstream
//   stall_cnt_o      out  saturating stall-cycle counter (COUNT_W)
//   bubble_cnt_o     out  saturating bubble counter (COUNT_W)
//   proto_err_o      out  sticky stall-protocol violation flag
//   dbg_action_o     out  per-cycle update decision (debug visibility)
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int DATA_W  = 112,
    parameter int COUNT_W = 16
);
    logic                stall_up_i;
    logic                stall_down_i;
    logic                flush_i;
    logic                in_valid_i;
    logic [DATA_W-1:0]   in_data_i;
    logic                in_next_dslot_i;
    logic                cnt_clr_i;
    logic                out_valid_o;
    logic [DATA_W-1:0]   out_data_o;
    logic                dslot_fb_o;
    logic [COUNT_W-1:0]  stall_cnt_o;
    logic [COUNT_W-1:0]  bubble_cnt_o;
    logic                proto_err_o;
    logic [2:0]          dbg_action_o;

    // Stall controller / upstream stage side.
    modport master (
        output stall_up_i, stall_down_i, flush_i, in_valid_i, in_data_i,
               in_next_dslot_i, cnt_clr_i,
        input  out_valid_o, out_data_o, dslot_fb_o, stall_cnt_o,
               bubble_cnt_o, proto_err_o, dbg_action_o
    );

    // Pipeline register side.
    modport slave (
        input  stall_up_i, stall_down_i, flush_i, in_valid_i, in_data_i,
               in_next_dslot_i, cnt_clr_i,
        output out_valid_o, out_data_o, dslot_fb_o, stall_cnt_o,
               bubble_cnt_o, proto_err_o, dbg_action_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Parametrised inter-stage pipeline register. It carries an opaque payload
// plus a valid bit and supports hold on stall, bubble insertion, flush, and
// delay-slot feedback to the upstream stage. It also keeps saturating
// stall/bubble counters for profiling. All outputs are registered, and no
// input reaches an output combinationally.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous reset, active-high
//   bus   slave modport of pipe_stage_reg_if (see that file for the signal list)
//
// Parameters:
//   DATA_W     payload width
//   NOP_VALUE  payload loaded on reset/flush/bubble; must decode as a NOP
//   COUNT_W    profiling counter width
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                DATA_W    = 112,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int                COUNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    pipe_stage_reg_if.slave bus
);

    // Update decision for payload/valid/dslot. The first matching case wins.
    typedef enum logic [2:0] {
        ACT_RESET  = 3'd0,
        ACT_FLUSH  = 3'd1,
        ACT_HOLD   = 3'd2,
        ACT_BUBBLE = 3'd3,
        ACT_LOAD   = 3'd4
    } action_t;

    action_t             w_action;
    logic                w_stall_any;
    logic                w_stall_inc;
    logic                w_bubble_inc;
    logic                w_proto_viol;

    logic                r_valid;
    logic [DATA_W-1:0]   r_data;
    logic                r_dslot;
    logic [COUNT_W-1:0]  r_stall_cnt;
    logic [COUNT_W-1:0]  r_bubble_cnt;
    logic                r_proto_err;
    action_t             r_last_action;

    // -----------------------------------------------------------------------
    // Decision logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_action = ACT_LOAD;
        if (rst)
            w_action = ACT_RESET;
        else if (bus.flush_i)
            w_action = ACT_FLUSH;
        else if (bus.stall_down_i)
            w_action = ACT_HOLD;
        else if (bus.stall_up_i)
            w_action = ACT_BUBBLE;
    end

    assign w_stall_any  = bus.stall_up_i | bus.stall_down_i;
    // A flush cycle is not a stall cycle even when a stall is also asserted.
    assign w_stall_inc  = w_stall_any & ~bus.flush_i;
    assign w_bubble_inc = (w_action == ACT_BUBBLE);
    // Downstream stalled while upstream keeps advancing. The upstream
    // instruction is then lost, because this register holds.
    assign w_proto_viol = bus.stall_down_i & ~bus.stall_up_i & ~bus.flush_i;

    // -----------------------------------------------------------------------
    // Payload / valid / delay-slot register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        case (w_action)
            ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
                r_valid <= 1'b0;
                r_data  <= NOP_VALUE;
                r_dslot <= 1'b0;
            end
            ACT_HOLD: begin
                r_valid <= r_valid;
                r_data  <= r_data;
                r_dslot <= r_dslot;
            end
            default: begin
                // An invalid load still captures the payload. Consumers gate on valid.
                r_valid <= bus.in_valid_i;
                r_data  <= bus.in_data_i;
                r_dslot <= bus.in_next_dslot_i;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Profiling counters: clear beats a same-cycle increment, and the
    // counters stick at all-ones instead of wrapping.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (bus.cnt_clr_i) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall_inc && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_bubble_inc && !(&r_bubble_cnt))
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Sticky protocol error and registered debug view of the decision
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_proto_err   <= 1'b0;
            r_last_action <= ACT_RESET;
        end else begin
            if (w_proto_viol)
                r_proto_err <= 1'b1;
            r_last_action <= w_action;
        end
    end

    assign bus.out_valid_o  = r_valid;
    assign bus.out_data_o   = r_data;
    assign bus.dslot_fb_o   = r_dslot;
    assign bus.stall_cnt_o  = r_stall_cnt;
    assign bus.bubble_cnt_o = r_bubble_cnt;
    assign bus.proto_err_o  = r_proto_err;
    assign bus.dbg_action_o = r_last_action;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed testbench for pipe_stage_reg. Two instances share the same
// stimulus. The first uses COUNT_W=16. The second uses COUNT_W=4, so its
// counters saturate within a short run.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DATA_W = 112;
    localparam logic [DATA_W-1:0] NOP = '0;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .COUNT_W(16)) ma ();
    pipe_stage_reg_if #(.DATA_W(DATA_W), .COUNT_W(4))  mb ();

    // The small-counter instance mirrors the stimulus of the main one.
    assign mb.stall_up_i      = ma.stall_up_i;
    assign mb.stall_down_i    = ma.stall_down_i;
    assign mb.flush_i         = ma.flush_i;
    assign mb.in_valid_i      = ma.in_valid_i;
    assign mb.in_data_i       = ma.in_data_i;
    assign mb.in_next_dslot_i = ma.in_next_dslot_i;
    assign mb.cnt_clr_i       = ma.cnt_clr_i;

    pipe_stage_reg #(.DATA_W(DATA_W), .NOP_VALUE(NOP), .COUNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ma)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .NOP_VALUE(NOP), .COUNT_W(4)) u_dut_small (
        .clk (clk),
        .rst (rst),
        .bus (mb)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        ma.stall_up_i      = 1'b0;
        ma.stall_down_i    = 1'b0;
        ma.flush_i         = 1'b0;
        ma.in_valid_i      = 1'b0;
        ma.in_data_i       = '0;
        ma.in_next_dslot_i = 1'b0;
        ma.cnt_clr_i       = 1'b0;
    endtask

    // Advance one clock edge. Outputs are then sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [DATA_W-1:0] d, input logic v, input logic ds);
        set_idle();
        ma.in_data_i       = d;
        ma.in_valid_i      = v;
        ma.in_next_dslot_i = ds;
        step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        ma.in_valid_i = 1'b1;
        ma.in_data_i  = {7{16'hABCD}};
        ma.stall_down_i = 1'b1;
        ma.stall_up_i   = 1'b0;
        step();
        step();
        n_checks++; if (ma.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", ma.out_valid_o); end
        n_checks++; if (ma.out_data_o !== NOP) begin n_fail++; $display("FAIL reset_data: got %h want %h", ma.out_data_o, NOP); end
        n_checks++; if (ma.dslot_fb_o !== 1'b0) begin n_fail++; $display("FAIL reset_dslot: got %0b want 0", ma.dslot_fb_o); end
        n_checks++; if (ma.stall_cnt_o !== 16'd0 || ma.bubble_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", ma.stall_cnt_o, ma.bubble_cnt_o); end
        n_checks++; if (ma.proto_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_proto: got %0b want 0", ma.proto_err_o); end
        n_checks++; if (mb.stall_cnt_o !== 4'd0 || mb.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_small: got cnt %0d valid %0b want 0/0", mb.stall_cnt_o, mb.out_valid_o); end
        rst = 1'b0;
        set_idle();
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] vals [3];
        vals[0] = 112'h11;
        vals[1] = 112'h22;
        vals[2] = 112'h33;
        for (int i = 0; i < 3; i++) begin
            drive_load(vals[i], 1'b1, 1'b0);
            n_checks++; if (ma.out_data_o !== vals[i] || ma.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL stream_%0d: got %h v%0b want %h v1", i, ma.out_data_o, ma.out_valid_o, vals[i]); end
        end
        // An invalid load still moves the payload.
        drive_load(112'h55, 1'b0, 1'b1);
        n_checks++; if (ma.out_data_o !== 112'h55 || ma.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_invalid: got %h v%0b want 55 v0", ma.out_data_o, ma.out_valid_o); end
        n_checks++; if (ma.dslot_fb_o !== 1'b1) begin n_fail++; $display("FAIL stream_dslot: got %0b want 1", ma.dslot_fb_o); end
        n_checks++; if (ma.stall_cnt_o !== 16'd0) begin n_fail++; $display("FAIL stream_no_stall: got %0d want 0", ma.stall_cnt_o); end
    endtask

    task automatic test_stall_hold();
        drive_load(112'h44, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_idle();
            ma.stall_up_i   = 1'b1;
            ma.stall_down_i = 1'b1;
            ma.in_valid_i   = 1'b1;
            ma.in_data_i    = 112'h99;
            step();
            n_checks++; if (ma.out_data_o !== 112'h44 || ma.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL hold_%0d: got %h v%0b want 44 v1", i, ma.out_data_o, ma.out_valid_o); end
        end
        n_checks++; if (ma.stall_cnt_o !== 16'd3) begin n_fail++; $display("FAIL hold_stall_cnt: got %0d want 3", ma.stall_cnt_o); end
        n_checks++; if (ma.bubble_cnt_o !== 16'd0) begin n_fail++; $display("FAIL hold_bubble_cnt: got %0d want 0", ma.bubble_cnt_o); end
        n_checks++; if (ma.proto_err_o !== 1'b0) begin n_fail++; $display("FAIL hold_proto: got %0b want 0", ma.proto_err_o); end
    endtask

    task automatic test_bubble();
        drive_load(112'h66, 1'b1, 1'b1);
        set_idle();
        ma.stall_up_i = 1'b1;
        ma.in_valid_i = 1'b1;
        ma.in_data_i  = 112'h88;
        ma.in_next_dslot_i = 1'b1;
        step();
        n_checks++; if (ma.out_valid_o !== 1'b0 || ma.out_data_o !== NOP) begin n_fail++; $display("FAIL bubble_payload: got %h v%0b want NOP v0", ma.out_data_o, ma.out_valid_o); end
        n_checks++; if (ma.dslot_fb_o !== 1'b0) begin n_fail++; $display("FAIL bubble_dslot: got %0b want 0", ma.dslot_fb_o); end
        n_checks++; if (ma.bubble_cnt_o !== 16'd1) begin n_fail++; $display("FAIL bubble_cnt: got %0d want 1", ma.bubble_cnt_o); end
        n_checks++; if (ma.stall_cnt_o !== 16'd4) begin n_fail++; $display("FAIL bubble_stall_cnt: got %0d want 4", ma.stall_cnt_o); end
    endtask

    task automatic test_flush();
        drive_load(112'h77, 1'b1, 1'b0);
        set_idle();
        ma.flush_i         = 1'b1;
        ma.stall_down_i    = 1'b1;
        ma.stall_up_i      = 1'b0;
        ma.in_valid_i      = 1'b1;
        ma.in_data_i       = 112'hAA;
        ma.in_next_dslot_i = 1'b1;
        step();
        n_checks++; if (ma.out_valid_o !== 1'b0 || ma.out_data_o !== NOP) begin n_fail++; $display("FAIL flush_payload: got %h v%0b want NOP v0", ma.out_data_o, ma.out_valid_o); end
        n_checks++; if (ma.dslot_fb_o !== 1'b0) begin n_fail++; $display("FAIL flush_dslot: got %0b want 0", ma.dslot_fb_o); end
        n_checks++; if (ma.stall_cnt_o !== 16'd4 || ma.bubble_cnt_o !== 16'd1) begin n_fail++; $display("FAIL flush_counters: got %0d/%0d want 4/1", ma.stall_cnt_o, ma.bubble_cnt_o); end
        n_checks++; if (ma.proto_err_o !== 1'b0) begin n_fail++; $display("FAIL flush_proto: got %0b want 0", ma.proto_err_o); end
        set_idle();
    endtask

    task automatic test_saturate_and_proto();
        // Clear the counters, then count 20 stalls.
        set_idle();
        ma.cnt_clr_i = 1'b1;
        step();
        n_checks++; if (ma.stall_cnt_o !== 16'd0 || ma.bubble_cnt_o !== 16'd0) begin n_fail++; $display("FAIL clr_counters: got %0d/%0d want 0/0", ma.stall_cnt_o, ma.bubble_cnt_o); end
        for (int i = 0; i < 20; i++) begin
            set_idle();
            ma.stall_up_i   = 1'b1;
            ma.stall_down_i = 1'b1;
            step();
        end
        n_checks++; if (mb.stall_cnt_o !== 4'd15) begin n_fail++; $display("FAIL sat_stall_small: got %0d want 15", mb.stall_cnt_o); end
        n_checks++; if (ma.stall_cnt_o !== 16'd20) begin n_fail++; $display("FAIL stall_wide: got %0d want 20", ma.stall_cnt_o); end
        // A clear that coincides with a stall still leaves the counters at zero.
        set_idle();
        ma.stall_up_i   = 1'b1;
        ma.stall_down_i = 1'b1;
        ma.cnt_clr_i    = 1'b1;
        step();
        n_checks++; if (mb.stall_cnt_o !== 4'd0 || ma.stall_cnt_o !== 16'd0) begin n_fail++; $display("FAIL clr_wins: got %0d/%0d want 0/0", mb.stall_cnt_o, ma.stall_cnt_o); end
        // Bubble counter saturation.
        for (int i = 0; i < 20; i++) begin
            set_idle();
            ma.stall_up_i = 1'b1;
            step();
        end
        n_checks++; if (mb.bubble_cnt_o !== 4'd15 || ma.bubble_cnt_o !== 16'd20) begin n_fail++; $display("FAIL sat_bubble: got %0d/%0d want 15/20", mb.bubble_cnt_o, ma.bubble_cnt_o); end
        // Downstream-only stall: the register holds and the error flag is set.
        drive_load(112'h5A, 1'b1, 1'b0);
        set_idle();
        ma.stall_down_i = 1'b1;
        ma.in_valid_i   = 1'b1;
        ma.in_data_i    = 112'hBB;
        step();
        n_checks++; if (ma.proto_err_o !== 1'b1) begin n_fail++; $display("FAIL proto_set: got %0b want 1", ma.proto_err_o); end
        n_checks++; if (ma.out_data_o !== 112'h5A || ma.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL proto_hold: got %h v%0b want 5a v1", ma.out_data_o, ma.out_valid_o); end
        for (int i = 0; i < 3; i++) drive_load(112'h1, 1'b1, 1'b0);
        n_checks++; if (ma.proto_err_o !== 1'b1 || mb.proto_err_o !== 1'b1) begin n_fail++; $display("FAIL proto_sticky: got %0b/%0b want 1/1", ma.proto_err_o, mb.proto_err_o); end
        set_idle();
        ma.cnt_clr_i = 1'b1;
        step();
        n_checks++; if (ma.proto_err_o !== 1'b1) begin n_fail++; $display("FAIL proto_not_cleared_by_clr: got %0b want 1", ma.proto_err_o); end
        set_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (ma.proto_err_o !== 1'b0) begin n_fail++; $display("FAIL proto_rst: got %0b want 0", ma.proto_err_o); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        set_idle();
        test_reset();
        test_stream();
        test_stall_hold();
        test_bubble();
        test_flush();
        test_saturate_and_proto();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
